ex_advint_iter: RTL and testbench

EX_ADVINT_ITER -- requirements
Module: ex_advint_iter

---
 rtl/ex_advint_iter_if.sv | 27 ++
 rtl/ex_advint_iter.sv | 187 ++++++++++++++++++
 tb/tb_ex_advint_iter.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/ex_advint_iter_if.sv
// Request/result bundle for the iterative multiply/divide unit.
// Master is the requester/consumer; slave is ex_advint_iter.
interface ex_advint_iter_if #(
  parameter int WIDTH = 64
);
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic [2:0]       unit;
  logic [1:0]       op;
  logic             in_valid;
  logic             in_ready;
  logic             flush;
  logic [WIDTH-1:0] out;
  logic [WIDTH-1:0] out2;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output in1, in2, unit, op, in_valid, flush, out_ready,
    input  in_ready, out, out2, out_valid
  );

  modport slave (
    input  in1, in2, unit, op, in_valid, flush, out_ready,
    output in_ready, out, out2, out_valid
  );
endinterface

// File: rtl/ex_advint_iter.sv
// Radix-2 iterative MUL/MULU/DIV/DIVU: WIDTH compute steps plus one fix-up cycle.
// Optional macro ADVINT_EARLY_OUT_EN skips the compute steps for zero operands / zero divisor.
module ex_advint_iter #(
  parameter int         WIDTH   = 64,
  parameter logic [2:0] UNIT_ID = 3'h4
) (
  input  logic             clk,
  input  logic             rst,
  ex_advint_iter_if.slave  bus
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0] out_q, out_d, out2_q, out2_d;
  logic [1:0]       op_q, op_d;
  logic             vld_q, vld_d;
  logic [CW-1:0]    cnt_q, cnt_d;
`ifdef ADVINT_EARLY_OUT_EN
  logic             hold_q, hold_d;
`endif

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic sgn);
    return (sgn && x[WIDTH-1]) ? ((~x) + WIDTH'(1)) : x;
  endfunction

  logic             sgn_in, sgn;
  logic [WIDTH-1:0] a_mag_in, b_mag_in, a_mag, b_mag;
  logic             accept;
  logic [WIDTH:0]   sum, shl, diff;
  logic [2*WIDTH-1:0] prod, prod_s;
  logic             neg;

  assign sgn_in   = ~bus.op[0];
  assign a_mag_in = mag(bus.in1, sgn_in);
  assign b_mag_in = mag(bus.in2, sgn_in);
  assign sgn      = ~op_q[0];
  assign a_mag    = mag(a_q, sgn);
  assign b_mag    = mag(b_q, sgn);
  assign accept   = bus.in_valid && (bus.unit == UNIT_ID);
  assign neg      = sgn && (a_q[WIDTH-1] ^ b_q[WIDTH-1]);

  // Shift-add multiply step and restoring divide step share the hi/lo pair.
  assign sum  = {1'b0, hi_q} + {1'b0, (lo_q[0] ? a_mag : {WIDTH{1'b0}})};
  assign shl  = {hi_q, lo_q[WIDTH-1]};
  assign diff = shl - {1'b0, b_mag};
  assign prod   = {hi_q, lo_q};
  assign prod_s = neg ? ((~prod) + (2*WIDTH)'(1)) : prod;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    out_d   = out_q;
    out2_d  = out2_q;
    op_d    = op_q;
    vld_d   = vld_q;
    cnt_d   = cnt_q;
`ifdef ADVINT_EARLY_OUT_EN
    hold_d  = hold_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          a_d     = bus.in1;
          b_d     = bus.in2;
          op_d    = bus.op;
          cnt_d   = '0;
          hi_d    = '0;
          lo_d    = bus.op[1] ? a_mag_in : b_mag_in;
          state_d = CALC;
`ifdef ADVINT_EARLY_OUT_EN
          if (bus.op[1] ? (bus.in2 == '0) : ((bus.in1 == '0) || (bus.in2 == '0))) begin
            state_d = FIX;
            hold_d  = 1'b1;
          end
`endif
        end
      end
      CALC: begin
        if (op_q[1]) begin
          if (!diff[WIDTH]) begin
            hi_d = diff[WIDTH-1:0];
            lo_d = {lo_q[WIDTH-2:0], 1'b1};
          end else begin
            hi_d = shl[WIDTH-1:0];
            lo_d = {lo_q[WIDTH-2:0], 1'b0};
          end
        end else begin
          hi_d = sum[WIDTH:1];
          lo_d = {sum[0], lo_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) state_d = FIX;
      end
      FIX: begin
`ifdef ADVINT_EARLY_OUT_EN
        // Early-out spends one settle cycle here so results land two edges after accept.
        if (hold_q) begin
          hold_d = 1'b0;
        end else
`endif
        begin
          if (op_q[1]) begin
            if (b_q == '0) begin
              out_d  = '1;
              out2_d = a_q;
            end else if (sgn && (a_q == {1'b1, {(WIDTH-1){1'b0}}}) && (b_q == '1)) begin
              out_d  = a_q;
              out2_d = '0;
            end else begin
              out_d  = neg ? ((~lo_q) + WIDTH'(1)) : lo_q;
              out2_d = (sgn && a_q[WIDTH-1]) ? ((~hi_q) + WIDTH'(1)) : hi_q;
            end
          end else if ((a_q == '0) || (b_q == '0)) begin
            out_d  = '0;
            out2_d = '0;
          end else begin
            out_d  = prod_s[WIDTH-1:0];
            out2_d = prod_s[2*WIDTH-1:WIDTH];
          end
          vld_d   = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          vld_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (bus.flush) begin
      state_d = IDLE;
      vld_d   = 1'b0;
      cnt_d   = '0;
`ifdef ADVINT_EARLY_OUT_EN
      hold_d  = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      out_q   <= '0;
      out2_q  <= '0;
      op_q    <= '0;
      vld_q   <= 1'b0;
      cnt_q   <= '0;
`ifdef ADVINT_EARLY_OUT_EN
      hold_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      out_q   <= out_d;
      out2_q  <= out2_d;
      op_q    <= op_d;
      vld_q   <= vld_d;
      cnt_q   <= cnt_d;
`ifdef ADVINT_EARLY_OUT_EN
      hold_q  <= hold_d;
`endif
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out       = out_q;
  assign bus.out2      = out2_q;
  assign bus.out_valid = vld_q;

endmodule

// File: tb/tb_ex_advint_iter.sv
// Directed bench for ex_advint_iter at WIDTH=64: results, latency, hold, flush and reset.
module tb_ex_advint_iter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_pass = 0;
  int   n_chk  = 0;
  int   lat;

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
`ifdef ADVINT_EARLY_OUT_EN
  localparam int LAT_DIV0 = 2;
`else
  localparam int LAT_DIV0 = 65;
`endif

  ex_advint_iter_if #(.WIDTH(64)) bus ();

  ex_advint_iter #(.WIDTH(64), .UNIT_ID(3'h4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Presents one request; returns just after the accepting edge.
  task automatic start_op(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b);
    @(negedge clk);
    bus.in1 = a; bus.in2 = b; bus.op = op; bus.unit = 3'h4; bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic wait_result(output int l);
    l = 0;
    while (!bus.out_valid && l < 200) begin
      @(posedge clk);
      #1 l++;
    end
  endtask

  task automatic release_result(input string tag);
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk({tag, "_rel_valid"}, 64'(bus.out_valid), 64'd0);
    chk({tag, "_rel_ready"}, 64'(bus.in_ready), 64'd1);
    bus.out_ready = 1'b0;
  endtask

  initial begin
    logic [63:0] hold_out, hold_out2;
    bus.in1 = '0; bus.in2 = '0; bus.op = '0; bus.unit = '0;
    bus.in_valid = 1'b0; bus.flush = 1'b0; bus.out_ready = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out", bus.out, 64'd0);
    chk("rst_out2", bus.out2, 64'd0);

    // Request for another unit must be ignored.
    @(negedge clk);
    bus.in1 = 64'd9; bus.in2 = 64'd9; bus.op = 2'd1; bus.unit = 3'h3; bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    chk("unit_mismatch_ready", 64'(bus.in_ready), 64'd1);
    repeat (3) @(posedge clk);
    #1 chk("unit_mismatch_valid", 64'(bus.out_valid), 64'd0);

    start_op(2'd1, ONES, 64'd2);
    wait_result(lat);
    chk("mulu_lat", 64'(lat), 64'd65);
    chk("mulu_out", bus.out, 64'hFFFF_FFFF_FFFF_FFFE);
    chk("mulu_out2", bus.out2, 64'd1);
    release_result("mulu");

    start_op(2'd0, -64'sd3, 64'd5);
    wait_result(lat);
    chk("mul_lat", 64'(lat), 64'd65);
    chk("mul_out", bus.out, 64'hFFFF_FFFF_FFFF_FFF1);
    chk("mul_out2", bus.out2, ONES);
    release_result("mul");

    start_op(2'd2, -64'sd7, 64'd2);
    wait_result(lat);
    chk("div_out", bus.out, 64'hFFFF_FFFF_FFFF_FFFD);
    chk("div_out2", bus.out2, ONES);
    release_result("div");

    start_op(2'd3, 64'd100, 64'd0);
    wait_result(lat);
    chk("divu0_lat", 64'(lat), 64'(LAT_DIV0));
    chk("divu0_out", bus.out, ONES);
    chk("divu0_out2", bus.out2, 64'd100);
    release_result("divu0");

    start_op(2'd2, 64'h8000_0000_0000_0000, ONES);
    wait_result(lat);
    chk("divovf_out", bus.out, 64'h8000_0000_0000_0000);
    chk("divovf_out2", bus.out2, 64'd0);
    release_result("divovf");

    start_op(2'd3, 64'd45, 64'd7);
    wait_result(lat);
    chk("divu_out", bus.out, 64'd6);
    chk("divu_out2", bus.out2, 64'd3);
    release_result("divu");

    // Result must hold while the consumer stalls.
    start_op(2'd1, 64'd6, 64'd7);
    wait_result(lat);
    chk("hold_out", bus.out, 64'd42);
    chk("hold_out2", bus.out2, 64'd0);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk("hold_valid", 64'(bus.out_valid), 64'd1);
      chk("hold_stable_out", bus.out, 64'd42);
      chk("hold_stable_out2", bus.out2, 64'd0);
      chk("hold_in_ready", 64'(bus.in_ready), 64'd0);
    end
    release_result("hold");

    // Flush at compute step 30.
    start_op(2'd1, 64'd1000, 64'd1000);
    repeat (29) @(posedge clk);
    @(negedge clk) bus.flush = 1'b1;
    @(posedge clk);
    #1 bus.flush = 1'b0;
    chk("flush_in_ready", 64'(bus.in_ready), 64'd1);
    chk("flush_out_valid", 64'(bus.out_valid), 64'd0);
    chk("flush_keep_out", bus.out, 64'd42);
    lat = 0;
    for (int i = 0; i < 70; i++) begin
      @(posedge clk);
      #1 if (bus.out_valid) lat++;
    end
    chk("flush_no_result", 64'(lat), 64'd0);
    start_op(2'd1, 64'd6, 64'd7);
    wait_result(lat);
    chk("flush_after_out", bus.out, 64'd42);
    chk("flush_after_out2", bus.out2, 64'd0);
    release_result("flush_after");

    // Reset at compute step 30.
    start_op(2'd1, 64'd1000, 64'd1000);
    repeat (29) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("midrst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("midrst_out", bus.out, 64'd0);
    chk("midrst_out2", bus.out2, 64'd0);
    lat = 0;
    for (int i = 0; i < 70; i++) begin
      @(posedge clk);
      #1 if (bus.out_valid) lat++;
    end
    chk("midrst_no_result", 64'(lat), 64'd0);
    start_op(2'd1, 64'd6, 64'd7);
    wait_result(lat);
    chk("midrst_after_lat", 64'(lat), 64'd65);
    chk("midrst_after_out", bus.out, 64'd42);
    chk("midrst_after_out2", bus.out2, 64'd0);
    release_result("midrst_after");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
